// File: rtl/fp_normalize_pack.sv
// Normalise, round-to-nearest-even and pack a raw single-precision add/sub mantissa.
// Iterative left normaliser (one bit per cycle), one operation in flight, valid/ready on both sides.
module fp_normalize_pack #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned MANT_W = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_word,
    output logic                    out_overflow,
    output logic                    out_inexact,
    output logic                    out_zero
);

    localparam int unsigned CAR     = MANT_W - 1;
    localparam int unsigned HID     = MANT_W - 2;
    localparam int unsigned SIG_W   = FRAC_W + 1;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned WORD_W  = EXP_W + FRAC_W + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SHIFT = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                in_ready_d, out_valid_d;
    logic [WORD_W-1:0]   out_word_d;
    logic                out_overflow_d, out_inexact_d, out_zero_d;

    // Rounding datapath on the normalised mantissa
    logic [SIG_W-1:0]    sig;
    logic                g_bit, r_bit, s_bit, rnd_inc, rnd_carry, rnd_ovf;
    logic [SIG_W:0]      rnd_sum;
    logic [SIG_W-1:0]    rnd_sig;
    logic [EW-1:0]       rnd_exp;
    logic [MANT_W-1:0]   mant_shl;
    logic [EW-1:0]       exp_dec;

    assign sig       = mant_q[HID:3];
    assign g_bit     = mant_q[2];
    assign r_bit     = mant_q[1];
    assign s_bit     = mant_q[0];
    assign rnd_inc   = g_bit & (r_bit | s_bit | mant_q[3]);
    assign rnd_sum   = {1'b0, sig} + (SIG_W+1)'(rnd_inc);
    assign rnd_carry = rnd_sum[SIG_W];
    assign rnd_sig   = rnd_carry ? rnd_sum[SIG_W:1] : rnd_sum[SIG_W-1:0];
    assign rnd_exp   = exp_q + EW'(rnd_carry);
    assign rnd_ovf   = (rnd_exp >= EW'(EXP_MAX));
    assign mant_shl  = {mant_q[MANT_W-2:0], 1'b0};
    assign exp_dec   = exp_q - EW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mant_q       <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_word     <= '0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            in_ready     <= in_ready_d;
            out_valid    <= out_valid_d;
            out_word     <= out_word_d;
            out_overflow <= out_overflow_d;
            out_inexact  <= out_inexact_d;
            out_zero     <= out_zero_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sign_d         = sign_q;
        exp_d          = exp_q;
        mant_d         = mant_q;
        out_valid_d    = 1'b0;
        out_word_d     = out_word;
        out_overflow_d = out_overflow;
        out_inexact_d  = out_inexact;
        out_zero_d     = out_zero;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_sign;
                    // Denormal operands carry exponent 0 but scale like exponent 1
                    exp_d   = (in_exp == '0) ? EW'(1) : EW'(in_exp);
                    mant_d  = in_mant;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mant_q == '0) begin
                    out_word_d     = '0;
                    out_zero_d     = 1'b1;
                    out_overflow_d = 1'b0;
                    out_inexact_d  = 1'b0;
                    state_d        = DONE;
                end else if (mant_q[CAR]) begin
                    mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EW'(1);
                    state_d = ROUND;
                end else if (mant_q[HID] || exp_q == EW'(1)) begin
                    state_d = ROUND;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                mant_d = mant_shl;
                exp_d  = exp_dec;
                if (mant_shl[HID] || exp_dec == EW'(1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_zero_d    = 1'b0;
                out_inexact_d = g_bit | r_bit | s_bit;
                if (rnd_ovf) begin
                    out_word_d     = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    out_overflow_d = 1'b1;
                end else begin
                    out_word_d     = {sign_q,
                                      rnd_sig[SIG_W-1] ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                                      rnd_sig[FRAC_W-1:0]};
                    out_overflow_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and drops after the handshake
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: directed table, reset/hold sequences and
// random operations checked against an arithmetic rounding model.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_overflow;
    logic        out_inexact;
    logic        out_zero;

    fp_normalize_pack dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic [31:0] word;
        logic        ovf;
        logic        inx;
        logic        zero;
        int          lat;
        int          hold;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input string what, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", tag, what, act, req);
        end
    endtask

    // Reference: exact value m * 2^(e-153), rounded RNE to the binary32 grid
    function automatic vec_t model(input logic sign, input logic [7:0] exp, input logic [27:0] mant);
        vec_t   v;
        longint e, big_e, e0, n, rem, half, m;
        int     msb, shamt;
        logic   up;
        v.sign = sign; v.exp = exp; v.mant = mant; v.hold = 0;
        v.ovf = 1'b0; v.inx = 1'b0; v.zero = 1'b0;
        e = (exp == 8'd0) ? 1 : longint'(exp);
        m = longint'(mant);
        if (m == 0) begin
            v.word = 32'h0; v.zero = 1'b1; v.lat = 2;
            return v;
        end
        msb = 0;
        for (int i = 0; i < 28; i++) if (mant[i]) msb = i;
        big_e = e + msb - 26;
        if (big_e < 1) big_e = 1;
        e0 = big_e;
        shamt = int'(big_e - e + 3);
        up = 1'b0;
        if (shamt > 0) begin
            n    = m >> shamt;
            rem  = m & ((longint'(1) << shamt) - 1);
            half = longint'(1) << (shamt - 1);
            up   = (rem > half) || (rem == half && n[0]);
        end else begin
            n   = m << (-shamt);
            rem = 0;
        end
        v.inx = (rem != 0);
        n = n + (up ? 1 : 0);
        if (n == (longint'(1) << 24)) begin
            n = longint'(1) << 23;
            big_e++;
        end
        if (big_e >= 255) begin
            v.ovf  = 1'b1;
            v.word = {sign, 8'hFF, 23'h0};
        end else begin
            v.word = {sign, (n >= (longint'(1) << 23)) ? big_e[7:0] : 8'h00, n[22:0]};
        end
        v.lat = (msb == 27) ? 3 : 3 + int'(e - e0);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        logic got;
        logic stable;
        @(negedge clk);
        in_sign = v.sign; in_exp = v.exp; in_mant = v.mant; in_valid = 1'b1;
        chk(tag, "in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 80 && !got) begin
            @(posedge clk); #1;
            lat++;
            got = out_valid;
        end
        chk(tag, "latency", longint'(lat), longint'(v.lat));
        if (!got) return;
        chk(tag, "word", longint'(out_word), longint'(v.word));
        chk(tag, "overflow", longint'(out_overflow), longint'(v.ovf));
        chk(tag, "inexact", longint'(out_inexact), longint'(v.inx));
        chk(tag, "zero", longint'(out_zero), longint'(v.zero));
        if (v.hold > 0) begin
            stable = 1'b1;
            repeat (v.hold) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || out_word != v.word) stable = 1'b0;
            end
            chk(tag, "hold_stable", longint'(stable), 1);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(tag, "valid_drop", longint'(out_valid), 0);
        chk(tag, "ready_back", longint'(in_ready), 1);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        logic seen;
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;

        //       sign  exp    mant          word          ovf   inx   zero  lat hold
        tbl[0] = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[1] = '{1'b0, 8'd127, 28'h1000000, 32'h3E800000, 1'b0, 1'b0, 1'b0, 5, 0};
        tbl[2] = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 1'b0, 3, 0};
        tbl[3] = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 1'b0, 3, 0};
        tbl[4] = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b1, 1'b0, 3, 0};
        tbl[5] = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 3, 0};
        tbl[6] = '{1'b1, 8'd100, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 2, 0};
        tbl[7] = '{1'b0, 8'd3,   28'h0200000, 32'h00100000, 1'b0, 1'b0, 1'b0, 5, 0};
        tbl[8] = '{1'b1, 8'd0,   28'h4000000, 32'h80800000, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[9] = '{1'b1, 8'd130, 28'h4000008, 32'hC1000001, 1'b0, 1'b0, 1'b0, 3, 10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset", "in_ready", longint'(in_ready), 1);
        chk("reset", "out_valid", longint'(out_valid), 0);
        chk("reset", "out_word", longint'(out_word), 0);
        chk("reset", "flags", longint'({out_overflow, out_inexact, out_zero}), 0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        // Reset while the normaliser is shifting must abandon the operation
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0000100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_shift", "in_ready", longint'(in_ready), 1);
        chk("rst_shift", "out_valid", longint'(out_valid), 0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_shift", "no_output", longint'(seen), 0);
        run_op(tbl[0], "after_rst");

        for (int i = 0; i < 150; i++) begin
            logic [27:0] m;
            logic [7:0]  e;
            m = 28'($urandom) >> $urandom_range(0, 28);
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(0, 4));
                1:       e = 8'($urandom_range(250, 254));
                default: e = 8'($urandom_range(0, 254));
            endcase
            v = model(1'($urandom), e, m);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
